// File: rtl/uart_loader_pkg.sv
// Shared types and helpers for the UART program loader.
package uart_loader_pkg;

    localparam int HDR_BYTES = 2;

    typedef enum logic [2:0] {
        IDLE,
        HDR_LO,
        HDR_HI,
        DATA,
        CHK,
        DONE,
        ERR
    } state_e;

    function automatic int bit_cycles(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling, glitch rejection.
module uart_rx_byte
    import uart_loader_pkg::*;
#(
    parameter int BIT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o
);

    localparam int CW   = $clog2(BIT_CYCLES + 1);
    localparam int HALF = (BIT_CYCLES / 2 > 0) ? BIT_CYCLES / 2 : 1;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic [1:0]    sync_q;
    logic          prev_q;
    logic [1:0]    st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          rx;

    assign rx = sync_q[1];

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (st_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !rx) st_d = RX_START;
            end
            RX_START: begin
                // Re-check mid start bit; a high line here is a glitch.
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d = '0;
                    bit_d = '0;
                    st_d  = rx ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == CW'(BIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rx, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) st_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == CW'(BIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    st_d    = RX_IDLE;
                    valid_d = rx;
                    ferr_d  = !rx;
                end
            end
            default: st_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            st_q    <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            prev_q  <= rx;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign byte_valid_o = valid_q;
    assign byte_data_o  = shift_q;
    assign frame_err_o  = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Loads a length-prefixed program image from UART into IMem while holding the CPU.
// Optional trailing XOR checksum byte enabled by LOADER_CHECKSUM_EN.
module uart_prog_loader
    import uart_loader_pkg::*;
#(
    parameter int CLK_HZ       = 23000000,
    parameter int BAUD         = 115200,
    parameter int ADDR_W       = 14,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_req,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int          BIT_CYCLES = bit_cycles(CLK_HZ, BAUD);
    localparam logic [31:0] TO_LAST    = 32'(TIMEOUT_BITS * BIT_CYCLES - 1);
    localparam logic [16:0] N_MAX      = 17'(1) << ADDR_W;

    logic       bvalid, ferr;
    logic [7:0] bdata;

    uart_rx_byte #(.BIT_CYCLES(BIT_CYCLES)) u_rx (
        .clk          (clk),
        .reset        (reset),
        .rx_i         (uart_rx),
        .byte_valid_o (bvalid),
        .byte_data_o  (bdata),
        .frame_err_o  (ferr)
    );

    state_e            state_q, state_d;
    logic [7:0]        n_lo_q, n_lo_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       word_q, word_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [31:0]       to_q, to_d;
    logic [16:0]       hdr;
    logic              active;
    state_e            end_st;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
    assign end_st = CHK;
`else
    assign end_st = DONE;
`endif

    assign active = (state_q == HDR_LO) || (state_q == HDR_HI) ||
                    (state_q == DATA) || (state_q == CHK);

    always_comb begin
        state_d = state_q;
        n_lo_d  = n_lo_q;
        n_d     = n_q;
        idx_d   = idx_q;
        word_d  = word_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        to_d    = (active && !bvalid) ? to_q + 32'd1 : 32'd0;
        hdr     = {1'b0, bdata, n_lo_q};
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (load_req) begin
                    state_d = HDR_LO;
                    idx_d   = '0;
                    waddr_d = '0;
                    cnt_d   = '0;
                    to_d    = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            HDR_LO: begin
                if (bvalid) begin
                    n_lo_d  = bdata;
                    state_d = HDR_HI;
                end
            end
            HDR_HI: begin
                if (bvalid) begin
                    n_d = hdr[ADDR_W:0];
                    if (hdr > N_MAX)      state_d = ERR;
                    else if (hdr == '0)   state_d = end_st;
                    else                  state_d = DATA;
                end
            end
            DATA: begin
                if (bvalid) begin
                    idx_d = idx_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ bdata;
`endif
                    case (idx_q)
                        2'd0: word_d[7:0]   = bdata;
                        2'd1: word_d[15:8]  = bdata;
                        2'd2: word_d[23:16] = bdata;
                        default: begin
                            we_d    = 1'b1;
                            wdata_d = {bdata, word_q};
                            waddr_d = cnt_q[ADDR_W-1:0];
                            cnt_d   = cnt_q + 1'b1;
                            if (cnt_q + 1'b1 == n_q) state_d = end_st;
                        end
                    endcase
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (bvalid) state_d = (bdata == csum_q) ? DONE : ERR;
            end
`endif
            default: state_d = IDLE;
        endcase
        // Errors abort any active load; written words stay in IMem.
        if (active && (ferr || (!bvalid && to_q == TO_LAST)))
            state_d = ERR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            n_lo_q  <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            to_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            n_lo_q  <= n_lo_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign imem_we      = we_q;
    assign imem_waddr   = waddr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_hold     = active;
    assign done         = (state_q == DONE);
    assign err          = (state_q == ERR);
    assign words_loaded = cnt_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader at 16 clocks per bit, ADDR_W=4.
module tb_uart_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_req = 1'b0;
    logic        uart_rx = 1'b1;
    logic        imem_we;
    logic [3:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_hold, done, err;
    logic [4:0]  words_loaded;

    int vectors = 0;
    int miscompares = 0;
    int wr_cnt = 0;
    int hold_viol = 0;
    bit mon_en = 1'b0;
    logic [3:0]  wa [0:15];
    logic [31:0] wd [0:15];

    uart_prog_loader #(
        .CLK_HZ(1600000), .BAUD(100000), .ADDR_W(4), .TIMEOUT_BITS(64)
    ) dut (
        .clk(clk), .reset(reset), .load_req(load_req), .uart_rx(uart_rx),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wr_cnt < 16) begin
                wa[wr_cnt] = imem_waddr;
                wd[wr_cnt] = imem_wdata;
            end
            wr_cnt++;
        end
        if (mon_en && (cpu_hold === (done | err))) hold_viol++;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (16) @(negedge clk);
        end
        uart_rx = stop;
        repeat (16) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_csum(input logic [7:0] c);
`ifdef LOADER_CHECKSUM_EN
        send_byte(c, 1'b1);
`else
        if (c === 8'hxx) $display("unreachable");
`endif
    endtask

    task automatic pulse_load();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({imem_we, imem_waddr, imem_wdata, cpu_hold, done, err, words_loaded} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got we=%b a=%h d=%h h=%b dn=%b e=%b wl=%0d expected all 0",
                     imem_we, imem_waddr, imem_wdata, cpu_hold, done, err, words_loaded);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_two_words();
        wr_cnt = 0;
        pulse_load();
        vectors++;
        if (cpu_hold !== 1'b1) begin
            miscompares++;
            $display("FAIL two_hold_start: got %b expected 1", cpu_hold);
        end
        send_byte(8'h02, 1); send_byte(8'h00, 1);
        send_byte(8'hEF, 1); send_byte(8'hBE, 1);
        send_byte(8'hAD, 1); send_byte(8'hDE, 1);
        send_byte(8'h13, 1); send_byte(8'h00, 1);
        send_byte(8'h50, 1); send_byte(8'h00, 1);
        send_csum(8'h61);
        repeat (20) @(negedge clk);
        vectors++;
        if (wr_cnt !== 2) begin
            miscompares++;
            $display("FAIL two_wr_count: got %0d expected 2", wr_cnt);
        end
        vectors++;
        if (wa[0] !== 4'd0 || wd[0] !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL two_word0: got %h@%0d expected deadbeef@0", wd[0], wa[0]);
        end
        vectors++;
        if (wa[1] !== 4'd1 || wd[1] !== 32'h00500013) begin
            miscompares++;
            $display("FAIL two_word1: got %h@%0d expected 00500013@1", wd[1], wa[1]);
        end
        vectors++;
        if ({done, err, cpu_hold} !== 3'b100 || words_loaded !== 5'd2) begin
            miscompares++;
            $display("FAIL two_end: got done=%b err=%b hold=%b wl=%0d expected 1 0 0 2",
                     done, err, cpu_hold, words_loaded);
        end
    endtask

    task automatic test_zero_len();
        wr_cnt = 0;
        hold_viol = 0;
        pulse_load();
        mon_en = 1'b1;
        send_byte(8'h00, 1); send_byte(8'h00, 1);
        send_csum(8'h00);
        repeat (20) @(negedge clk);
        mon_en = 1'b0;
        vectors++;
        if (hold_viol !== 0) begin
            miscompares++;
            $display("FAIL zero_hold_window: got %0d bad cycles expected 0", hold_viol);
        end
        vectors++;
        if (done !== 1'b1 || wr_cnt !== 0 || words_loaded !== 5'd0) begin
            miscompares++;
            $display("FAIL zero_end: got done=%b writes=%0d wl=%0d expected 1 0 0",
                     done, wr_cnt, words_loaded);
        end
    endtask

    task automatic test_bad_stop();
        wr_cnt = 0;
        pulse_load();
        send_byte(8'h01, 1); send_byte(8'h00, 1);
        send_byte(8'h11, 1); send_byte(8'h22, 1);
        send_byte(8'h33, 1); send_byte(8'h44, 0);
        repeat (10) @(negedge clk);
        vectors++;
        if ({err, cpu_hold, done} !== 3'b100) begin
            miscompares++;
            $display("FAIL badstop_state: got err=%b hold=%b done=%b expected 1 0 0",
                     err, cpu_hold, done);
        end
        vectors++;
        if (wr_cnt !== 0 || words_loaded !== 5'd0) begin
            miscompares++;
            $display("FAIL badstop_writes: got %0d/%0d expected 0/0", wr_cnt, words_loaded);
        end
    endtask

    task automatic test_oversize();
        wr_cnt = 0;
        pulse_load();
        send_byte(8'h11, 1); send_byte(8'h00, 1);
        vectors++;
        if ({err, cpu_hold} !== 2'b10 || wr_cnt !== 0) begin
            miscompares++;
            $display("FAIL oversize: got err=%b hold=%b writes=%0d expected 1 0 0",
                     err, cpu_hold, wr_cnt);
        end
    endtask

    task automatic test_glitch();
        wr_cnt = 0;
        pulse_load();
        send_byte(8'h01, 1); send_byte(8'h00, 1);
        send_byte(8'h78, 1); send_byte(8'h56, 1);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        vectors++;
        if ({err, cpu_hold} !== 2'b01) begin
            miscompares++;
            $display("FAIL glitch_noerr: got err=%b hold=%b expected 0 1", err, cpu_hold);
        end
        send_byte(8'h34, 1); send_byte(8'h12, 1);
        send_csum(8'h08);
        repeat (20) @(negedge clk);
        vectors++;
        if (wr_cnt !== 1 || wd[0] !== 32'h12345678 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch_word: got n=%0d d=%h done=%b expected 1 12345678 1",
                     wr_cnt, wd[0], done);
        end
    endtask

    task automatic test_timeout();
        bit seen;
        wr_cnt = 0;
        seen = 1'b0;
        pulse_load();
        send_byte(8'h02, 1); send_byte(8'h00, 1);
        send_byte(8'h01, 1); send_byte(8'h02, 1); send_byte(8'h03, 1);
        send_byte(8'h04, 1); send_byte(8'h05, 1);
        repeat (990) @(negedge clk);
        vectors++;
        if ({err, cpu_hold} !== 2'b01) begin
            miscompares++;
            $display("FAIL timeout_early: got err=%b hold=%b expected 0 1", err, cpu_hold);
        end
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (err === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen || cpu_hold !== 1'b0 || wr_cnt !== 1) begin
            miscompares++;
            $display("FAIL timeout_err: got err=%b hold=%b writes=%0d expected 1 0 1",
                     seen, cpu_hold, wr_cnt);
        end
    endtask

    task automatic test_reset_mid();
        pulse_load();
        send_byte(8'h02, 1); send_byte(8'h00, 1);
        send_byte(8'hAA, 1); send_byte(8'hBB, 1);
        send_byte(8'hCC, 1); send_byte(8'hDD, 1);
        send_byte(8'h11, 1); send_byte(8'h22, 1);
        vectors++;
        if (cpu_hold !== 1'b1 || words_loaded !== 5'd1 || imem_wdata !== 32'hDDCCBBAA) begin
            miscompares++;
            $display("FAIL resetmid_pre: got hold=%b wl=%0d d=%h expected 1 1 ddccbbaa",
                     cpu_hold, words_loaded, imem_wdata);
        end
        reset = 1'b1;
        load_req = 1'b1;
        @(negedge clk);
        vectors++;
        if ({imem_we, imem_waddr, imem_wdata, cpu_hold, done, err, words_loaded} !== '0) begin
            miscompares++;
            $display("FAIL resetmid_clear: got h=%b wl=%0d d=%h expected all 0",
                     cpu_hold, words_loaded, imem_wdata);
        end
        reset = 1'b0;
        load_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (cpu_hold !== 1'b0) begin
            miscompares++;
            $display("FAIL resetmid_reqdrop: got hold=%b expected 0", cpu_hold);
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        for (int k = 0; k < 2; k++) begin
            wr_cnt = 0;
            pulse_load();
            send_byte(8'h01, 1); send_byte(8'h00, 1);
            send_byte(8'h01, 1); send_byte(8'h02, 1);
            send_byte(8'h03, 1); send_byte(8'h04, 1);
            send_byte((k == 0) ? 8'h04 : 8'h05, 1);
            repeat (10) @(negedge clk);
            chk(k == 0 ? "csum_ok_state" : "csum_bad_state",
                {30'd0, done, err}, (k == 0) ? 32'd2 : 32'd1);
            chk("csum_write", wd[0], 32'h04030201);
            chk("csum_wcount", 32'(wr_cnt), 32'd1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_two_words();
        test_zero_len();
        test_bad_stop();
        test_oversize();
        test_glitch();
        test_timeout();
        test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`else
        chk("idle_after_reset", {31'd0, done}, 32'd0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
